spram_arbiter: RTL and testbench

- Shares one spram instance between NUM_REQ requesters.
- Round-robin arbitration with one access per cycle. Each requester has a valid/ready request channel and a valid/ready read-response channel.
- Sits directly in front of spram and drives its din/addr/wen/en. spram resetn is tied high or driven separately; its 1-cycle registered read latency is absorbed here.

---
 rtl/spram_arbiter.sv | 162 ++++++++++++++++
 tb/tb_spram_arbiter.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spram_arbiter.sv
// spram_arbiter: shares one single-port RAM between NUM_REQ requesters.
// One access per cycle, round-robin arbitration, one outstanding read whose
// response is taken straight from the RAM's registered dout.
// Optional build macro SPRAM_ARB_FIXED_PRIO_EN selects fixed priority
// (lowest index wins) instead of round-robin.
module spram_arbiter #(
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned WORD_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_wen,
    input  logic [NUM_REQ*WORD_DEPTH-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]              rsp_valid,
    input  logic [NUM_REQ-1:0]              rsp_ready,
    output logic [DATA_WIDTH-1:0]           rsp_data,
    output logic                            ram_en,
    output logic                            ram_wen,
    output logic [WORD_DEPTH-1:0]           ram_addr,
    output logic [DATA_WIDTH-1:0]           ram_din,
    input  logic [DATA_WIDTH-1:0]           ram_dout
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic                 rd_pending_q, rd_pending_d;
    logic [PTR_W-1:0]     rd_owner_q, rd_owner_d;
    logic [PTR_W-1:0]     start_ptr;

    logic                 rsp_fire;
    logic                 slot_free;
    logic [NUM_REQ-1:0]   eligible;

    logic                 grant_vld;
    logic [PTR_W-1:0]     grant_idx;
    logic                 grant_rd;

`ifdef SPRAM_ARB_FIXED_PRIO_EN
    assign start_ptr = '0;
`else
    logic [PTR_W-1:0]     rr_ptr_q, rr_ptr_d;
    assign start_ptr = rr_ptr_q;
`endif

    // Response side: owner of the pending read sees valid; data is the RAM dout.
    always_comb begin
        rsp_valid = '0;
        if (!reset && rd_pending_q) begin
            rsp_valid[rd_owner_q] = 1'b1;
        end
        rsp_data  = ram_dout;
        rsp_fire  = |(rsp_valid & rsp_ready);
        slot_free = !rd_pending_q || rsp_fire;
    end

    // Eligibility: writes always, reads only when the response slot frees up.
    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            eligible[i] = !reset && req_valid[i] && (req_wen[i] || slot_free);
        end
    end

    // Rotating search: indices at/after start_ptr beat those below it, which
    // is the modulo-NUM_REQ wrap expressed without a runtime modulo.
    always_comb begin
        logic             hi_vld, lo_vld;
        logic [PTR_W-1:0] hi_idx, lo_idx;
        hi_vld = 1'b0;
        lo_vld = 1'b0;
        hi_idx = '0;
        lo_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (eligible[i]) begin
                if (i >= 32'(start_ptr)) begin
                    if (!hi_vld) begin
                        hi_vld = 1'b1;
                        hi_idx = PTR_W'(i);
                    end
                end else if (!lo_vld) begin
                    lo_vld = 1'b1;
                    lo_idx = PTR_W'(i);
                end
            end
        end
        grant_vld = hi_vld || lo_vld;
        grant_idx = hi_vld ? hi_idx : lo_idx;
    end

    // Issue the granted request to the RAM in the same cycle.
    always_comb begin
        req_ready = '0;
        ram_en    = 1'b0;
        ram_wen   = 1'b0;
        ram_addr  = '0;
        ram_din   = '0;
        grant_rd  = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_vld && (32'(grant_idx) == i)) begin
                req_ready[i] = 1'b1;
                ram_en       = 1'b1;
                ram_wen      = req_wen[i];
                ram_addr     = req_addr[i*WORD_DEPTH +: WORD_DEPTH];
                ram_din      = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
                grant_rd     = !req_wen[i];
            end
        end
    end

    // Next state: an accepted response frees the slot unless a new read
    // is granted in the same cycle, which re-arms it for the new owner.
    always_comb begin
        rd_pending_d = rd_pending_q;
        rd_owner_d   = rd_owner_q;
        if (rsp_fire) begin
            rd_pending_d = 1'b0;
        end
        if (grant_rd) begin
            rd_pending_d = 1'b1;
            rd_owner_d   = grant_idx;
        end
    end

`ifndef SPRAM_ARB_FIXED_PRIO_EN
    // Round-robin pointer advances past the most recent grant.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant_vld) begin
            if (32'(grant_idx) == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + PTR_W'(1);
            end
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    // Read-slot state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_pending_q <= 1'b0;
            rd_owner_q   <= '0;
        end else begin
            rd_pending_q <= rd_pending_d;
            rd_owner_q   <= rd_owner_d;
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// tb_spram_arbiter: directed + random stimulus against a transaction-level
// model (grant rule, one read slot, shadow memory). Includes a simple spram
// behavioural model as the environment. Honours SPRAM_ARB_FIXED_PRIO_EN.
module tb_spram_arbiter;

    localparam int unsigned N     = 2;
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 2;
    localparam int unsigned DEPTH = 1 << AW;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      req_valid, req_ready, req_wen, rsp_valid, rsp_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*DW-1:0]   req_wdata;
    logic [DW-1:0]     rsp_data, ram_din, ram_dout;
    logic              ram_en, ram_wen;
    logic [AW-1:0]     ram_addr;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    spram_arbiter #(
        .NUM_REQ    (N),
        .DATA_WIDTH (DW),
        .WORD_DEPTH (AW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_wen   (req_wen),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .ram_en    (ram_en),
        .ram_wen   (ram_wen),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    // spram environment: registered read, writes leave dout unchanged.
    logic [DW-1:0] ram_mem [DEPTH];
    logic [DW-1:0] ram_dout_r;
    assign ram_dout = ram_dout_r;
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_wen) ram_mem[ram_addr] <= ram_din;
            else         ram_dout_r        <= ram_mem[ram_addr];
        end
    end

    // Reference model state.
    int            m_ptr;
    bit            m_pend;
    int            m_owner;
    logic [DW-1:0] m_mem [DEPTH];
    logic [DW-1:0] m_rdata;
    int            last_grant;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input int a, input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_wen[i]            = w;
        req_addr[i*AW +: AW]  = AW'(a);
        req_wdata[i*DW +: DW] = d;
    endtask

    // One clock: check DUT at negedge against the model, then advance the model.
    task automatic do_cycle();
        int            g;
        int            idx;
        bit            slot_free;
        logic [N-1:0]  exp_ready, exp_rvalid;
        logic [AW-1:0] ga;
        logic [DW-1:0] gd;
        @(negedge clk);
        g = -1;
        exp_ready  = '0;
        exp_rvalid = '0;
        ga = '0;
        gd = '0;
        if (!reset) begin
            if (m_pend) exp_rvalid[m_owner] = 1'b1;
            slot_free = !m_pend || rsp_ready[m_owner];
            for (int k = 0; k < N; k++) begin
                idx = (m_ptr + k) % N;
                if (g < 0 && req_valid[idx] && (req_wen[idx] || slot_free)) g = idx;
            end
        end
        if (g >= 0) begin
            exp_ready[g] = 1'b1;
            ga = req_addr[g*AW +: AW];
            gd = req_wdata[g*DW +: DW];
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        chk("rsp_valid", 64'(rsp_valid), 64'(exp_rvalid));
        if (exp_rvalid != '0) chk("rsp_data", 64'(rsp_data), 64'(m_rdata));
        chk("ram_en", 64'(ram_en), 64'(g >= 0));
        chk("ram_wen", 64'(ram_wen), (g >= 0) ? 64'(req_wen[g]) : 64'(0));
        chk("ram_addr", 64'(ram_addr), 64'(ga));
        chk("ram_din", 64'(ram_din), 64'(gd));
        last_grant = g;
        @(posedge clk);
        if (reset) begin
            m_ptr   = 0;
            m_pend  = 1'b0;
            m_owner = 0;
        end else begin
            if (m_pend && rsp_ready[m_owner]) m_pend = 1'b0;
            if (g >= 0) begin
`ifdef SPRAM_ARB_FIXED_PRIO_EN
                m_ptr = 0;
`else
                m_ptr = (g + 1) % N;
`endif
                if (req_wen[g]) begin
                    m_mem[ga] = gd;
                end else begin
                    m_pend  = 1'b1;
                    m_owner = g;
                    m_rdata = m_mem[ga];
                end
            end
        end
        #1;
    endtask

    initial begin
        reset      = 1'b1;
        req_valid  = '0;
        req_wen    = '0;
        req_addr   = '0;
        req_wdata  = '0;
        rsp_ready  = '0;
        ram_dout_r = '0;
        m_ptr      = 0;
        m_pend     = 1'b0;
        m_owner    = 0;
        m_rdata    = '0;
        last_grant = -1;
        for (int a = 0; a < DEPTH; a++) begin
            ram_mem[a] = '0;
            m_mem[a]   = '0;
        end

        // Reset held with both requesters valid: nothing may be issued.
        set_req(0, 1'b1, 1'b1, 1, 32'hDEADBEEF);
        set_req(1, 1'b1, 1'b1, 2, 32'h12345678);
        repeat (3) do_cycle();
        reset = 1'b0;
        do_cycle();
        chk("first_grant_after_reset", 64'(last_grant), 64'(0));
        set_req(0, 1'b0, 1'b0, 0, '0);
        do_cycle();
        set_req(1, 1'b0, 1'b0, 0, '0);

        // Read back the write to addr 1.
        rsp_ready = 2'b11;
        set_req(0, 1'b1, 1'b0, 1, '0);
        do_cycle();
        set_req(0, 1'b0, 1'b0, 0, '0);
        do_cycle();
        set_req(0, 1'b1, 1'b1, 0, 32'h0BADF00D);
        do_cycle();
        set_req(0, 1'b0, 1'b0, 0, '0);

        // Back-to-back reads from both requesters.
        set_req(0, 1'b1, 1'b0, 0, '0);
        set_req(1, 1'b1, 1'b0, 3, '0);
        repeat (4) do_cycle();
        set_req(0, 1'b0, 1'b0, 0, '0);
        set_req(1, 1'b0, 1'b0, 0, '0);
        do_cycle();

        // Stalled response: reads blocked, writes still go through.
        rsp_ready = 2'b01;
        set_req(1, 1'b1, 1'b0, 2, '0);
        do_cycle();
        set_req(1, 1'b0, 1'b0, 0, '0);
        set_req(0, 1'b1, 1'b0, 0, '0);
        repeat (2) do_cycle();
        set_req(0, 1'b1, 1'b1, 0, 32'h5555AAAA);
        do_cycle();
        set_req(0, 1'b1, 1'b0, 0, '0);
        repeat (2) do_cycle();
        chk("stalled_rsp_data", 64'(rsp_data), 64'(32'h12345678));
        rsp_ready = 2'b11;
        do_cycle();
        set_req(0, 1'b0, 1'b0, 0, '0);
        do_cycle();

        // Read then same-address write: old data returned.
        set_req(0, 1'b1, 1'b0, 3, '0);
        do_cycle();
        set_req(0, 1'b0, 1'b0, 0, '0);
        set_req(1, 1'b1, 1'b1, 3, 32'hA5A5A5A5);
        do_cycle();
        set_req(1, 1'b0, 1'b0, 0, '0);
        set_req(0, 1'b1, 1'b0, 3, '0);
        do_cycle();
        set_req(0, 1'b0, 1'b0, 0, '0);
        do_cycle();

        // Reset while a read response is outstanding.
        rsp_ready = 2'b00;
        set_req(0, 1'b1, 1'b0, 1, '0);
        do_cycle();
        set_req(0, 1'b0, 1'b0, 0, '0);
        reset = 1'b1;
        do_cycle();
        reset = 1'b0;
        do_cycle();
        rsp_ready = 2'b11;
        set_req(0, 1'b1, 1'b0, 1, '0);
        do_cycle();
        set_req(0, 1'b0, 1'b0, 0, '0);
        do_cycle();

        // Random traffic; a request is held until accepted.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || last_grant == i) begin
                    set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                            int'($urandom_range(0, DEPTH - 1)), DW'($urandom));
                end
                rsp_ready[i] = $urandom_range(0, 3) != 0;
            end
            reset = ($urandom_range(0, 59) == 0);
            do_cycle();
        end
        reset = 1'b0;
        req_valid = '0;
        do_cycle();

        // RAM contents must match every write the model saw granted.
        for (int a = 0; a < DEPTH; a++) begin
            chk("ram_contents", 64'(ram_mem[a]), 64'(m_mem[a]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
